// File: rtl/pu_pio_master_pkg.sv
// Shared PU PIO definitions: sequencer state encoding, PIO range, default timeout
// and the memory-select address field used by the decode stage.
package pu_pio_master_pkg;

  localparam int PU_PIO_NBITS      = 32;
  localparam int PU_TIMEOUT_CYCLES = 1024;
  localparam int PU_TO_W           = 11;

  // Memory-select field occupies the top byte of a PIO address.
  localparam int                  PU_MSEL_LSB          = 24;
  localparam int                  PU_MSEL_W            = 8;
  localparam logic [PU_MSEL_W-1:0] PU_MSEL_CONN_CONTEXT = 8'h03;
  localparam logic [PU_MSEL_W-1:0] PU_MSEL_SWITCH_INFO  = 8'h05;
  localparam logic [PU_MSEL_W-1:0] PU_MSEL_UNMAPPED     = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } pio_state_e;

  function automatic logic [PU_PIO_NBITS-1:0] pu_pio_addr(input logic [PU_MSEL_W-1:0] msel,
                                                          input logic [PU_MSEL_LSB-1:0] offset);
    return {msel, offset};
  endfunction

endpackage

// File: rtl/pu_pio_timeout_cnt.sv
// Clear/enable up-counter for the PIO wait timeout; expire flags the last
// enabled cycle before the limit is reached.
module pu_pio_timeout_cnt #(
  parameter int LIMIT = 1024,
  parameter int W     = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else if (en)    cnt_q <= cnt_q + 1'b1;
  end

  assign expire = en && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/pu_pio_master.sv
// Host-to-PU PIO sequencer: one outstanding register request, timeout abort, drain of stale acks.
// Optional error logging (err_addr / err_cnt ports) with PU_PIO_MASTER_ERR_LOG_EN.
module pu_pio_master
  import pu_pio_master_pkg::*;
#(
  parameter int PIO_NBITS      = PU_PIO_NBITS,
  parameter int TIMEOUT_CYCLES = PU_TIMEOUT_CYCLES,
  parameter int TO_W           = PU_TO_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_div,
  input  logic                 host_req,
  input  logic                 host_wr,
  input  logic [PIO_NBITS-1:0] host_addr,
  input  logic [PIO_NBITS-1:0] host_wdata,
  output logic                 host_gnt,
  output logic                 host_resp_valid,
  output logic [PIO_NBITS-1:0] host_rdata,
  output logic                 host_err,
  output logic                 reg_bs,
  output logic                 reg_rd,
  output logic                 reg_wr,
  output logic [PIO_NBITS-1:0] reg_addr,
  output logic [PIO_NBITS-1:0] reg_din,
  input  logic                 pio_ack,
  input  logic                 pio_rvalid,
  input  logic [PIO_NBITS-1:0] pio_rdata
`ifdef PU_PIO_MASTER_ERR_LOG_EN
  ,
  output logic [PIO_NBITS-1:0] err_addr,
  output logic [7:0]           err_cnt
`endif
);

  pio_state_e state_q, state_d;
  logic       is_wr_q;
  logic       start, done, abort, expire;

  pu_pio_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES), .W(TO_W)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != ST_WAIT),
    .en     (state_q == ST_WAIT),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start = host_req;
        if (host_req) state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // Completion beats a simultaneous expiry.
        done  = is_wr_q ? pio_ack : pio_rvalid;
        abort = !done && expire;
        if (done || abort) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (clk_div && !pio_ack && !pio_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      host_gnt        <= 1'b0;
      host_resp_valid <= 1'b0;
      host_rdata      <= '0;
      host_err        <= 1'b0;
      reg_bs          <= 1'b0;
      reg_rd          <= 1'b0;
      reg_wr          <= 1'b0;
      reg_addr        <= '0;
      reg_din         <= '0;
      is_wr_q         <= 1'b0;
    end else begin
      host_gnt        <= 1'b0;
      host_resp_valid <= 1'b0;
      host_err        <= 1'b0;
      reg_rd          <= 1'b0;
      reg_wr          <= 1'b0;
      if (start) begin
        host_gnt <= 1'b1;
        reg_bs   <= 1'b1;
        reg_addr <= host_addr;
        reg_din  <= host_wdata;
        is_wr_q  <= host_wr;
        reg_wr   <= host_wr;
        reg_rd   <= !host_wr;
      end
      if (done || abort) begin
        reg_bs          <= 1'b0;
        host_resp_valid <= 1'b1;
        host_err        <= abort;
        host_rdata      <= (done && !is_wr_q) ? pio_rdata : '0;
      end
      if (state_q == ST_RESP) host_rdata <= '0;
    end
  end

`ifdef PU_PIO_MASTER_ERR_LOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (abort) begin
      err_addr <= reg_addr;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pu_pio_master.sv
// Self-checking bench for pu_pio_master with a clk_div-paced decoder model.
module tb_pu_pio_master;
  import pu_pio_master_pkg::*;

  localparam int NB = PU_PIO_NBITS;
  localparam int TO = PU_TIMEOUT_CYCLES;

  logic          clk = 1'b0, rst = 1'b1, clk_div = 1'b0;
  logic          host_req = 1'b0, host_wr = 1'b0;
  logic [NB-1:0] host_addr = '0, host_wdata = '0, pio_rdata = '0;
  logic          pio_ack = 1'b0, pio_rvalid = 1'b0;
  logic          host_gnt, host_resp_valid, host_err, reg_bs, reg_rd, reg_wr;
  logic [NB-1:0] host_rdata, reg_addr, reg_din;
`ifdef PU_PIO_MASTER_ERR_LOG_EN
  logic [NB-1:0] err_addr;
  logic [7:0]    err_cnt;
`endif

  int nchk = 0, nfail = 0;
  int cyc = 0, div_cnt = 0, quiet = 0, dec_resp_cyc = 0;
  int dec_wait = 0, dec_hold = 0, dec_left = 0;
  logic dec_busy = 1'b0, dec_wr = 1'b0, dec_silent = 1'b0, dec_noise = 1'b0;
  logic [NB-1:0] dec_rdata = '0;
  int exp_err_cnt = 0;
  logic [NB-1:0] exp_err_addr = '0;

  pu_pio_master dut (
    .clk(clk), .rst(rst), .clk_div(clk_div),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_resp_valid(host_resp_valid), .host_rdata(host_rdata), .host_err(host_err),
    .reg_bs(reg_bs), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_din(reg_din),
    .pio_ack(pio_ack), .pio_rvalid(pio_rvalid), .pio_rdata(pio_rdata)
`ifdef PU_PIO_MASTER_ERR_LOG_EN
    , .err_addr(err_addr), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Decoder model: clk_div every 4th clk, response after two clk_div pulses,
  // held for one clk_div period plus dec_hold extra periods.
  initial forever begin
    @(negedge clk);
    cyc++;
    div_cnt = (div_cnt == 3) ? 0 : div_cnt + 1;
    clk_div = (div_cnt == 0);
    if (rst) begin
      dec_busy = 1'b0; pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0;
    end else if (!dec_busy) begin
      if ((reg_wr || reg_rd) && !dec_silent) begin
        dec_busy = 1'b1; dec_wr = reg_wr; dec_wait = 2; dec_left = dec_hold;
      end
    end else if (clk_div) begin
      if (dec_wait == 2) begin
        dec_wait = 1;
        if (dec_noise) begin
          if (dec_wr) begin pio_rvalid = 1'b1; pio_rdata = $urandom; end
          else pio_ack = 1'b1;
        end
      end else if (dec_wait == 1) begin
        dec_wait = 0;
        pio_ack = dec_wr; pio_rvalid = !dec_wr;
        pio_rdata = dec_wr ? NB'($urandom) : dec_rdata;
        dec_resp_cyc = cyc;
      end else if (dec_left > 0) begin
        dec_left--;
      end else begin
        pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0; dec_busy = 1'b0;
      end
    end
    quiet = (pio_ack || pio_rvalid) ? 0 : quiet + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_errlog(input string tag);
`ifdef PU_PIO_MASTER_ERR_LOG_EN
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err_cnt));
    chk({tag, "_err_addr"}, err_addr, exp_err_addr);
`endif
  endtask

  task automatic wait_gnt(input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk); #1;
      got = host_gnt;
    end
    chk({tag, "_gnt"}, 32'(got), 32'd1);
  endtask

  task automatic run_txn(input logic wr, input logic [NB-1:0] addr, input logic [NB-1:0] wdata,
                         input logic [NB-1:0] rdata, input logic silent, input logic noise,
                         input int hold, input logic keep_req, input string tag);
    int lat = 0, wr_p, rd_p;
    logic got = 1'b0, bs_ok = 1'b1;
    logic [NB-1:0] exp_rdata;
    dec_silent = silent; dec_noise = noise; dec_hold = hold; dec_rdata = rdata;
    host_wr = wr; host_addr = addr; host_wdata = wdata; host_req = 1'b1;
    wait_gnt(tag);
    if (!keep_req) host_req = 1'b0;
    chk({tag, "_quiet_before_gnt"}, 32'(quiet >= 2), 32'd1);
    chk({tag, "_addr"}, reg_addr, addr);
    chk({tag, "_din"}, reg_din, wdata);
    chk({tag, "_bs"}, 32'(reg_bs), 32'd1);
    wr_p = int'(reg_wr); rd_p = int'(reg_rd);
    for (int i = 0; i < TO + 64 && !got; i++) begin
      @(negedge clk); #1;
      lat++;
      if (host_resp_valid) got = 1'b1;
      else begin
        wr_p += int'(reg_wr); rd_p += int'(reg_rd);
        if (!reg_bs || reg_addr !== addr || reg_din !== wdata) bs_ok = 1'b0;
      end
    end
    // Reference: silent decoder -> timeout error, no data; writes never return data.
    exp_rdata = (wr || silent) ? '0 : rdata;
    if (silent) begin
      exp_err_cnt  = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
      exp_err_addr = addr;
    end
    chk({tag, "_resp"}, 32'(got), 32'd1);
    chk({tag, "_err"}, 32'(host_err), 32'(silent));
    chk({tag, "_rdata"}, host_rdata, exp_rdata);
    chk({tag, "_bs_low"}, 32'(reg_bs), 32'd0);
    chk({tag, "_wr_pulses"}, 32'(wr_p), 32'(wr));
    chk({tag, "_rd_pulses"}, 32'(rd_p), 32'(!wr));
    chk({tag, "_bs_held"}, 32'(bs_ok), 32'd1);
    if (silent) chk({tag, "_latency"}, 32'(lat), 32'(TO + 1));
    else        chk({tag, "_latency"}, 32'(cyc), 32'(dec_resp_cyc + 1));
    chk_errlog(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] a, d, r;
    logic wr;
    int extra;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(host_gnt), 32'd0);
    chk("rst_resp_valid", 32'(host_resp_valid), 32'd0);
    chk("rst_rdata", host_rdata, 32'd0);
    chk("rst_err", 32'(host_err), 32'd0);
    chk("rst_bs", 32'(reg_bs), 32'd0);
    chk("rst_rd", 32'(reg_rd), 32'd0);
    chk("rst_wr", 32'(reg_wr), 32'd0);
    chk("rst_addr", reg_addr, 32'd0);
    chk("rst_din", reg_din, 32'd0);
    chk_errlog("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_txn(1'b1, pu_pio_addr(PU_MSEL_CONN_CONTEXT, 24'h000040), 32'hDEADBEEF, '0, 1'b0, 1'b0, 0, 1'b0, "wr_conn");
    run_txn(1'b0, pu_pio_addr(PU_MSEL_SWITCH_INFO, 24'h000108), 32'h0, 32'h12345678, 1'b0, 1'b1, 0, 1'b0, "rd_switch");

    for (int i = 0; i < 8; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = pu_pio_addr(($urandom_range(0, 1) == 0) ? PU_MSEL_CONN_CONTEXT : PU_MSEL_SWITCH_INFO, 24'($urandom));
      d  = $urandom;
      r  = $urandom;
      run_txn(wr, a, d, r, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 1), 1'b0, $sformatf("rnd%0d", i));
    end

    run_txn(1'b0, pu_pio_addr(PU_MSEL_UNMAPPED, 24'h00ABC0), 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0, "rd_timeout");

    run_txn(1'b1, pu_pio_addr(PU_MSEL_CONN_CONTEXT, 24'h000010), 32'h11112222, '0, 1'b0, 1'b0, 1, 1'b1, "b2b_first");
    run_txn(1'b1, pu_pio_addr(PU_MSEL_CONN_CONTEXT, 24'h000014), 32'h33334444, '0, 1'b0, 1'b0, 1, 1'b0, "b2b_second");
    extra = 0;
    repeat (24) begin
      @(negedge clk); #1;
      extra += int'(host_gnt) + int'(host_resp_valid);
    end
    chk("b2b_no_extra", 32'(extra), 32'd0);

    dec_silent = 1'b1;
    host_wr = 1'b0; host_addr = pu_pio_addr(PU_MSEL_SWITCH_INFO, 24'h000200); host_req = 1'b1;
    wait_gnt("rst_wait");
    host_req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_bs", 32'(reg_bs), 32'd0);
    chk("midrst_rd", 32'(reg_rd), 32'd0);
    chk("midrst_wr", 32'(reg_wr), 32'd0);
    chk("midrst_resp_valid", 32'(host_resp_valid), 32'd0);
    chk("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b0;
    exp_err_cnt = 0; exp_err_addr = '0;
    @(negedge clk);
    run_txn(1'b0, pu_pio_addr(PU_MSEL_SWITCH_INFO, 24'h000204), 32'h0, 32'hCAFE0123, 1'b0, 1'b0, 0, 1'b0, "rd_after_rst");

    dec_silent = 1'b1;
    r = $urandom;
    host_wr = 1'b0; host_addr = pu_pio_addr(PU_MSEL_SWITCH_INFO, 24'h000300); host_req = 1'b1;
    wait_gnt("edge");
    host_req = 1'b0;
    repeat (TO) @(negedge clk);
    #1;
    pio_rvalid = 1'b1; pio_rdata = r;
    @(negedge clk); #1;
    chk("edge_resp", 32'(host_resp_valid), 32'd1);
    chk("edge_err", 32'(host_err), 32'd0);
    chk("edge_rdata", host_rdata, r);
    pio_rvalid = 1'b0; pio_rdata = '0;
    chk_errlog("edge");
    repeat (10) @(negedge clk);
    dec_silent = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/pu_pio_master.md
Name: pu_pio_master

Overview:
- Upstream sequencer for the PU register/memory PIO decode stage.
- Converts single host register requests (CPU/debug bridge) into the PU PIO bus strobes `reg_bs`, `reg_rd`, `reg_wr`, `reg_addr`, `reg_din`.
- Waits for the decoder's registered `pio_ack` (write) or `pio_rvalid` (read), returns the response to the host, and enforces a timeout.
- One transaction outstanding at a time.

Parameters:
- PIO_NBITS, 32, PIO address/data width (matches the PIO range define).
- TIMEOUT_CYCLES, 1024, clk cycles in WAIT before the transaction is aborted with error.
- TO_W, 11, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- clk_div  in  1  PIO sample-enable pulse, shared with the decode stage.
- host_req  in  1  host request valid; held until host_gnt.
- host_wr  in  1  1=write, 0=read; qualified by host_req.
- host_addr  in  PIO_NBITS  request address.
- host_wdata  in  PIO_NBITS  write data.
- host_gnt  out  1  one-cycle request accept.
- host_resp_valid  out  1  one-cycle completion pulse.
- host_rdata  out  PIO_NBITS  read data; valid with host_resp_valid; 0 for writes and errors.
- host_err  out  1  timeout flag; valid with host_resp_valid.
- reg_bs  out  1  block select; held high from ISSUE through completion.
- reg_rd  out  1  one-clk read strobe.
- reg_wr  out  1  one-clk write strobe.
- reg_addr  out  PIO_NBITS  address; stable while reg_bs is high.
- reg_din  out  PIO_NBITS  write data; stable while reg_bs is high.
- pio_ack  in  1  write/none-selected acknowledge from the decode stage.
- pio_rvalid  in  1  read data valid from the decode stage.
- pio_rdata  in  PIO_NBITS  read data; sampled when pio_rvalid is high.

Behaviour:
- Reset: all outputs are 0, state=IDLE, timeout counter=0.
- All outputs are registered.
- State machine:
  - IDLE: when host_req=1, pulse host_gnt, latch addr/wdata/wr into reg_addr/reg_din, set reg_bs=1, go to ISSUE.
  - ISSUE: drive reg_rd (read) or reg_wr (write) high for exactly one clk, independent of clk_div. Go to WAIT with the counter cleared.
  - WAIT:
    - Write completes on pio_ack=1.
    - Read completes on pio_rvalid=1; host_rdata captures pio_rdata in the same cycle.
    - A read ignores pio_ack. A write ignores pio_rvalid.
    - The counter increments every clk. When it reaches TIMEOUT_CYCLES-1 without completion, the transaction aborts.
    - On completion or abort: deassert reg_bs next cycle, go to RESP.
  - RESP: host_resp_valid=1 for one clk; host_err=1 only on abort. Go to DRAIN.
  - DRAIN: hold reg_bs=0 until pio_ack=0 and pio_rvalid=0 have been sampled on a clk_div=1 cycle. Then go to IDLE. This prevents a stale acknowledge from completing the next transaction.
- Latency: host_gnt to host_resp_valid is at least 3 clk plus decoder latency (two clk_div periods).
- If completion and timeout occur in the same cycle, completion wins and host_err=0.
- host_req arriving outside IDLE is not granted; the host holds it.
- Mid-operation reset returns to IDLE with strobes low. The decode stage's own reset clears its state.

Optional Feature:
- Macro: PU_PIO_MASTER_ERR_LOG_EN.
- When defined, add two ports, both cleared by rst:
  - err_addr (out, PIO_NBITS): captures reg_addr on every abort.
  - err_cnt (out, 8): saturating count of aborts.
- When undefined, the ports are absent. Abort behaviour is otherwise identical.

Decomposition:
- Shared PU package/defines hold:
  - state encoding (IDLE, ISSUE, WAIT, RESP, DRAIN);
  - PIO_NBITS/PIO range;
  - the default TIMEOUT_CYCLES;
  - the PU memory-select address field constants already used by the decode stage.
- One natural sub-module, pu_pio_timeout_cnt: clear/enable counter with an expire output. Everything else stays inline.

Test Plan:
- Write 0xDEADBEEF to a conn_context address with clk_div every 4th clk:
  - reg_wr pulses once; reg_bs is held until pio_ack.
  - host_resp_valid=1, host_err=0, host_rdata=0.
- Read from a switch_info address with the model returning 0x12345678:
  - reg_rd pulses once.
  - host_rdata=0x12345678, host_err=0; pio_ack is ignored throughout.
- Read to an unmapped address with the decoder model never asserting pio_rvalid:
  - After 1024 clk: host_resp_valid=1, host_err=1, host_rdata=0.
  - With ERR_LOG_EN: err_addr = that address and err_cnt=1.
- Back-to-back: host_req held across two writes with pio_ack held high one extra clk_div period:
  - Second host_gnt does not occur until DRAIN observes pio_ack=0.
  - Exactly two responses.
- Assert rst while in WAIT:
  - Next cycle reg_bs=0, reg_rd=0, reg_wr=0, host_resp_valid=0, state=IDLE.
  - A subsequent read completes normally.
- pio_rvalid asserted in the same clk the counter expires:
  - host_err=0 and the data is returned.
